// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with count, almost flags and overflow/underflow pulses
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE = (ADDR_WIDTH+1)'(AE_THRESH);
  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  assign full = count == DEPTH;
  assign empty = count == '0;
  assign almost_full = count >= AF;
  assign almost_empty = count <= AE;
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(wr_acc);
      rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(rd_acc);
      count <= count + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);
      overflow <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end
  // memory is deliberately left uninitialised by reset
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end
`ifdef FIFO_FWFT_EN
  assign rd_data = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
`else
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else if (rd_acc) rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end
`endif
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed scoreboard bench for sync_fifo_flags (either read mode)
module tb_sync_fifo_flags;
  logic clk = 0, reset = 1, wr_en = 0, rd_en = 0;
  logic [7:0] wr_data = 0, rd_data;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  logic [7:0] q[$];
  logic [7:0] exp_rd = 0;
  int passed = 0, total = 0;

  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input bit w, input logic [7:0] d, input bit r, input bit rs);
    bit ov, un, wacc, racc;
    int n;
    reset = rs; wr_en = w; wr_data = d; rd_en = r;
    n = q.size();
    ov = !rs && w && n == 16;
    un = !rs && r && n == 0;
    wacc = w && n < 16;
    racc = r && n > 0;
    @(posedge clk); #1;
    if (rs) begin
      q.delete();
      exp_rd = 0;
    end else begin
      if (racc) exp_rd = q.pop_front();
      if (wacc) q.push_back(d);
    end
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == 16));
    chk("almost_full", 32'(almost_full), 32'(n >= 14));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk("overflow", 32'(overflow), 32'(ov));
    chk("underflow", 32'(underflow), 32'(un));
`ifdef FIFO_FWFT_EN
    chk("rd_data", 32'(rd_data), n > 0 ? 32'(q[0]) : 32'h0);
`else
    chk("rd_data", 32'(rd_data), 32'(exp_rd));
`endif
  endtask

  initial begin
    tick(0, 8'h00, 0, 1);
    tick(1, 8'h55, 1, 1);
    tick(0, 8'h00, 0, 0);
    tick(0, 8'h00, 0, 0);
    tick(1, 8'hAA, 0, 0);
    tick(1, 8'hBB, 0, 0);
    tick(1, 8'hCC, 0, 0);
    repeat (4) tick(0, 8'h00, 1, 0);
    for (int i = 0; i < 16; i++) tick(1, 8'(i), 0, 0);
    tick(1, 8'hFF, 0, 0);
    tick(0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) tick(0, 8'h00, 1, 0);
    tick(0, 8'h00, 1, 0);
    tick(0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) tick(1, 8'h30 + 8'(i), 0, 0);
    tick(1, 8'h40, 1, 0);
    for (int i = 0; i < 11; i++) tick(1, 8'h50 + 8'(i), 0, 0);
    tick(1, 8'hEE, 1, 0);
    tick(1, 8'hEF, 1, 0);
    for (int i = 0; i < 16; i++) tick(0, 8'h00, 1, 0);
    tick(1, 8'h77, 1, 0);
    tick(0, 8'h00, 1, 0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) tick(1, 8'(8'h80 + r * 10 + i), 0, 0);
      for (int i = 0; i < 10; i++) tick(0, 8'h00, 1, 0);
    end
    for (int i = 0; i < 7; i++) tick(1, 8'hC0 + 8'(i), 0, 0);
    tick(0, 8'h00, 1, 0);
    tick(1, 8'hC7, 0, 0);
    tick(1, 8'hD0, 1, 1);
    tick(0, 8'h00, 0, 0);
    tick(0, 8'h00, 1, 0);
    tick(1, 8'hAA, 0, 0);
    tick(0, 8'h00, 0, 0);
    tick(0, 8'h00, 1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
